mux_serializer: RTL and testbench
=================================

# mux_serializer

Parallel-to-serial converter built around the team's 8:1 bit selector. It accepts an 8-bit word over a valid/ready handshake and registers it. A 3-bit select counter then drives the selector, presenting one bit per accepted output beat. The block sits directly upstream of serial consumers such as the UART/LED-shift demo stages, and replaces ad-hoc select counters wired to `mux8to1` in top levels.

## Interface
Parameters:
- `LSB_FIRST`, default 1: 1 gives select order 0→7; 0 gives select order 7→0.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on rising `clk`.
- `D`  in  8  parallel word, sampled when `in_valid && in_ready`.
- `in_valid`  in  1  upstream has a word.
- `in_ready`  out  1  block can accept a word this cycle.
- `Y`  out  1  current serial bit (selector output).
- `out_valid`  out  1  `Y` is a valid bit.
- `out_ready`  in  1  downstream consumes `Y` this cycle.
- `S`  out  3  current select index (debug/probe).
- `last`  out  1  high while the bit on `Y` is the 8th bit of the word.

## Operation
- State machine with two states.
  - `IDLE`: `out_valid=0`, `in_ready=1`. On accept, go to `SEND`, load `word_q<=D`, and load `S` with the start index (0 if `LSB_FIRST`, else 7).
  - `SEND`: `out_valid=1` and `Y=word_q[S]`. On each transfer (`out_valid && out_ready`), step `S` (+1 if `LSB_FIRST`, else −1).
- `last` = (`S==7` when `LSB_FIRST`) or (`S==0` when not), qualified by the `SEND` state.
- `in_ready = (state==IDLE) || (last && out_ready)`. This allows back-to-back words with no bubble.
- Transfer of the last bit:
  - If `in_valid` is high, reload `word_q` and the start index and stay in `SEND`.
  - Otherwise, go to `IDLE`.
- If `out_ready=0` in `SEND`: hold `S`, `word_q`, `Y`, `out_valid` and `last` stable. No bit is skipped or duplicated.
- `D` is ignored unless accepted. Changes on `D` after acceptance do not affect the word in flight.
- Counter arithmetic is 3-bit unsigned. The counter never wraps inside a word because the last-bit transfer reloads or exits first.

## Timing
- Reset (`rst_n=0` at a rising edge):
  - state=`IDLE`, `word_q=0`, `S=0`.
  - Outputs: `out_valid=0`, `last=0`, `in_ready=1`, `Y=0`.
- Reset asserted mid-word discards the word in flight. The output returns to the reset values after that edge.
- Latency: a word accepted at edge k presents its first bit valid during cycle k+1. With `out_ready` held high, the 8 bits occupy cycles k+1..k+8. `last` is high in cycle k+8.
- Throughput: one bit per cycle. With continuous `in_valid`, the next word's first bit follows in cycle k+9.
- `Y` is combinational from registers only (`word_q`, `S`). There is no combinational path from `D` or `in_valid` to `Y`.
- `in_ready` depends combinationally on `out_ready` only in the last-bit cycle.

## Structure
- Shared package `ser_pkg` holds:
  - localparams `ST_IDLE=1'b0` and `ST_SEND=1'b1`;
  - `SEL_W=3` and `WORD_W=8`.
- One sub-module instance: the existing `mux8to1` (`D=word_q`, `S=S`, `Y=Y`). Select logic is not re-implemented inline.
- The FSM, counter and handshake live in `mux_serializer`, targeting 120–200 lines.

## Test plan
- Reset: hold `rst_n=0` for 3 cycles with `in_valid=1` and `D=8'hFF` → `out_valid=0`, `in_ready=1`, `S=0`, `Y=0`, and no word accepted.
- `LSB_FIRST=1`: send `D=8'h1E` with `out_ready=1` → `Y` = 0,1,1,1,1,0,0,0 in cycles k+1..k+8, `last` only at k+8, `S` = 0..7.
- `LSB_FIRST=0`: send `D=8'h1E` → `Y` = 0,0,0,1,1,1,1,0 and `S` = 7..0.
- Backpressure: with `D=8'h1E` (LSB-first), drop `out_ready` for 2 cycles at the 3rd bit → `Y=1` and `S=2` held for those cycles, and the stream remains exactly 8 transfers.
- Back-to-back: `in_valid` held with `8'h1E` then `8'hA0` → 16 consecutive valid cycles, `in_ready` high only in cycle k+8 during `SEND`, and the second word's bits are 0,0,0,0,0,1,0,1.
- Mid-word reset: assert `rst_n=0` during the 4th bit of `8'h1E` → `out_valid=0` next cycle. A subsequent word `8'hFF` then streams eight 1s.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared definitions for the parallel-to-serial path: state encodings and widths.
package ser_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SEND = 1'b1;

  localparam int unsigned SEL_W  = 3;
  localparam int unsigned WORD_W = 8;

  typedef enum logic {
    IDLE = ST_IDLE,
    SEND = ST_SEND
  } state_e;

endpackage

// File: rtl/mux_serializer_if.sv
// Word-in / bit-out handshake bundle for mux_serializer.
interface mux_serializer_if;
  import ser_pkg::*;

  logic [WORD_W-1:0] D;
  logic              in_valid;
  logic              in_ready;
  logic              Y;
  logic              out_valid;
  logic              out_ready;
  logic [SEL_W-1:0]  S;
  logic              last;

  modport master (
    output D, in_valid, out_ready,
    input  in_ready, Y, out_valid, S, last
  );

  modport slave (
    input  D, in_valid, out_ready,
    output in_ready, Y, out_valid, S, last
  );
endinterface

// File: rtl/mux8to1.sv
// 8:1 bit selector: Y is bit S of D.
module mux8to1 (
  input  logic [7:0] D,
  input  logic [2:0] S,
  output logic       Y
);

  // Pure selection, no state.
  always_comb begin
    Y = D[S];
  end

endmodule

// File: rtl/mux_serializer.sv
// Parallel-to-serial converter: registers an 8-bit word and walks a 3-bit
// select counter across the shared 8:1 selector, one bit per output beat.
module mux_serializer
  import ser_pkg::*;
#(
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_serializer_if.slave bus
);

  localparam logic [SEL_W-1:0] SEL_START = (LSB_FIRST != 0) ? '0 : '1;
  localparam logic [SEL_W-1:0] SEL_FINAL = (LSB_FIRST != 0) ? '1 : '0;
  // Adding all-ones is a decrement in 3-bit arithmetic.
  localparam logic [SEL_W-1:0] SEL_STEP  = (LSB_FIRST != 0) ? SEL_W'(1) : '1;

  state_e            state_q;
  logic [WORD_W-1:0] word_q;
  logic [SEL_W-1:0]  sel_q;
  logic              y_w;
  logic              last_w;
  logic              in_ready_w;

  mux8to1 u_sel (
    .D (word_q),
    .S (sel_q),
    .Y (y_w)
  );

  // Last-bit flag and acceptance; in_ready only looks at out_ready on the final bit.
  always_comb begin
    last_w     = (state_q == SEND) && (sel_q == SEL_FINAL);
    in_ready_w = (state_q == IDLE) || (last_w && bus.out_ready);
  end

  assign bus.Y         = y_w;
  assign bus.S         = sel_q;
  assign bus.last      = last_w;
  assign bus.out_valid = (state_q == SEND);
  assign bus.in_ready  = in_ready_w;

  // FSM, word register and select counter; holds everything while out_ready is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      sel_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            state_q <= SEND;
            word_q  <= bus.D;
            sel_q   <= SEL_START;
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            if (last_w) begin
              // Reload on the final beat so back-to-back words have no bubble.
              if (bus.in_valid) begin
                word_q <= bus.D;
                sel_q  <= SEL_START;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              sel_q <= sel_q + SEL_STEP;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_serializer.sv
// Bench for mux_serializer: LSB-first and MSB-first instances share stimulus
// and are checked against a bit-count reference model plus fixed sequences.
module tb_mux_serializer;
  import ser_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mux_serializer_if bus_l ();
  mux_serializer_if bus_m ();

  mux_serializer #(.LSB_FIRST(1)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bus_l));
  mux_serializer #(.LSB_FIRST(0)) dut_m (.clk(clk), .rst_n(rst_n), .bus(bus_m));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: busy flag, word in flight, bits already transferred.
  bit       m_busy  = 1'b0;
  bit       m_fresh = 1'b0;
  logic [7:0] m_word = 8'h00;
  int       m_n     = 0;

  logic       e_valid, e_last, e_rdy, e_yl, e_ym;
  logic [2:0] e_sl, e_sm;
  logic [7:0] cur_d;
  logic       cur_vin, cur_ordy, cur_rstn;

  task automatic setup(input logic [7:0] d, input logic vin, input logic ordy, input logic rstn);
    @(negedge clk);
    cur_d = d; cur_vin = vin; cur_ordy = ordy; cur_rstn = rstn;
    bus_l.D = d; bus_l.in_valid = vin; bus_l.out_ready = ordy;
    bus_m.D = d; bus_m.in_valid = vin; bus_m.out_ready = ordy;
    rst_n = rstn;
    e_valid = m_busy;
    e_last  = m_busy && (m_n == 7);
    e_rdy   = !m_busy || ((m_n == 7) && ordy);
    e_sl    = m_fresh ? 3'd0 : 3'(m_n);
    e_sm    = m_fresh ? 3'd0 : 3'(7 - m_n);
    e_yl    = m_word[e_sl];
    e_ym    = m_word[e_sm];
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!cur_rstn) begin
      m_busy = 1'b0; m_word = 8'h00; m_n = 0; m_fresh = 1'b1;
    end else if (!m_busy) begin
      if (cur_vin) begin
        m_busy = 1'b1; m_word = cur_d; m_n = 0; m_fresh = 1'b0;
      end
    end else if (cur_ordy) begin
      if (m_n == 7) begin
        if (cur_vin) begin m_word = cur_d; m_n = 0; end
        else m_busy = 1'b0;
      end else begin
        m_n++;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      setup(8'hFF, 1'b1, 1'b1, 1'b0);
      tick();
    end
    setup(8'h00, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if ({bus_l.out_valid, bus_l.in_ready, bus_l.S, bus_l.Y, bus_l.last} !== 7'b0_1_000_0_0) begin
      n_bad++;
      $display("FAIL reset_lsb got %b want %b", {bus_l.out_valid, bus_l.in_ready, bus_l.S, bus_l.Y, bus_l.last}, 7'b0100000);
    end
    n_cmp++;
    if ({bus_m.out_valid, bus_m.in_ready, bus_m.S, bus_m.Y, bus_m.last} !== 7'b0_1_000_0_0) begin
      n_bad++;
      $display("FAIL reset_msb got %b want %b", {bus_m.out_valid, bus_m.in_ready, bus_m.S, bus_m.Y, bus_m.last}, 7'b0100000);
    end
    tick();
    setup(8'h00, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if ({bus_l.out_valid, bus_m.out_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_no_accept got %b want 00", {bus_l.out_valid, bus_m.out_valid});
    end
    tick();
  endtask

  task automatic test_single();
    bit exp_yl [8] = '{0, 1, 1, 1, 1, 0, 0, 0};
    bit exp_ym [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
    setup(8'h1E, 1'b1, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      setup(8'($urandom), 1'b0, 1'b1, 1'b1);
      n_cmp++;
      if ({bus_l.out_valid, bus_l.Y, bus_l.S, bus_l.last} !== {1'b1, exp_yl[i], 3'(i), (i == 7)}) begin
        n_bad++;
        $display("FAIL single_lsb beat %0d got %b want %b", i, {bus_l.out_valid, bus_l.Y, bus_l.S, bus_l.last}, {1'b1, exp_yl[i], 3'(i), (i == 7)});
      end
      n_cmp++;
      if ({bus_m.out_valid, bus_m.Y, bus_m.S, bus_m.last} !== {1'b1, exp_ym[i], 3'(7 - i), (i == 7)}) begin
        n_bad++;
        $display("FAIL single_msb beat %0d got %b want %b", i, {bus_m.out_valid, bus_m.Y, bus_m.S, bus_m.last}, {1'b1, exp_ym[i], 3'(7 - i), (i == 7)});
      end
      tick();
    end
    setup(8'h00, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if ({bus_l.out_valid, bus_m.out_valid, bus_l.in_ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL single_end got %b want 001", {bus_l.out_valid, bus_m.out_valid, bus_l.in_ready});
    end
    tick();
  endtask

  task automatic test_backpressure();
    int  xfers = 0;
    logic ordy;
    setup(8'h1E, 1'b1, 1'b1, 1'b1);
    tick();
    for (int j = 0; j < 12; j++) begin
      ordy = !(j == 2 || j == 3);
      setup(8'($urandom), 1'b0, ordy, 1'b1);
      n_cmp++;
      if ({bus_l.out_valid, bus_l.last, bus_l.in_ready, bus_l.Y, bus_l.S} !== {e_valid, e_last, e_rdy, e_yl, e_sl}) begin
        n_bad++;
        $display("FAIL bp_lsb cyc %0d got %b want %b", j, {bus_l.out_valid, bus_l.last, bus_l.in_ready, bus_l.Y, bus_l.S}, {e_valid, e_last, e_rdy, e_yl, e_sl});
      end
      if (!ordy) begin
        n_cmp++;
        if ({bus_l.Y, bus_l.S} !== 4'b1_010) begin
          n_bad++;
          $display("FAIL bp_hold cyc %0d got %b want 1010", j, {bus_l.Y, bus_l.S});
        end
      end
      if (bus_l.out_valid && ordy) xfers++;
      tick();
    end
    n_cmp++;
    if (xfers != 8) begin
      n_bad++;
      $display("FAIL bp_xfer_count got %0d want 8", xfers);
    end
  endtask

  task automatic test_back_to_back();
    bit exp_b [8] = '{0, 0, 0, 0, 0, 1, 0, 1};
    logic [7:0] d;
    setup(8'h1E, 1'b1, 1'b1, 1'b1);
    tick();
    for (int i = 1; i <= 16; i++) begin
      d = (i == 8) ? 8'hA0 : 8'($urandom);
      setup(d, (i <= 8), 1'b1, 1'b1);
      n_cmp++;
      if ({bus_l.out_valid, bus_m.out_valid, bus_l.in_ready, bus_m.in_ready} !== {2'b11, {2{(i == 8) || (i == 16)}}}) begin
        n_bad++;
        $display("FAIL b2b_ctl cyc %0d got %b want %b", i, {bus_l.out_valid, bus_m.out_valid, bus_l.in_ready, bus_m.in_ready}, {2'b11, {2{(i == 8) || (i == 16)}}});
      end
      if (i >= 9) begin
        n_cmp++;
        if (bus_l.Y !== exp_b[i - 9]) begin
          n_bad++;
          $display("FAIL b2b_word2 bit %0d got %b want %b", i - 9, bus_l.Y, exp_b[i - 9]);
        end
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    setup(8'h1E, 1'b1, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      setup(8'h00, 1'b0, 1'b1, (i != 3));
      tick();
    end
    setup(8'hFF, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if ({bus_l.out_valid, bus_m.out_valid, bus_l.in_ready, bus_l.S, bus_l.Y} !== 7'b00_1_000_0) begin
      n_bad++;
      $display("FAIL midrst_idle got %b want 0010000", {bus_l.out_valid, bus_m.out_valid, bus_l.in_ready, bus_l.S, bus_l.Y});
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      setup(8'h00, 1'b0, 1'b1, 1'b1);
      n_cmp++;
      if ({bus_l.out_valid, bus_l.Y, bus_m.out_valid, bus_m.Y} !== 4'b1111) begin
        n_bad++;
        $display("FAIL midrst_ones beat %0d got %b want 1111", i, {bus_l.out_valid, bus_l.Y, bus_m.out_valid, bus_m.Y});
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      setup(8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) != 0));
      n_cmp++;
      if ({bus_l.out_valid, bus_l.last, bus_l.in_ready} !== {e_valid, e_last, e_rdy}) begin
        n_bad++;
        $display("FAIL rnd_ctl_lsb cyc %0d got %b want %b", c, {bus_l.out_valid, bus_l.last, bus_l.in_ready}, {e_valid, e_last, e_rdy});
      end
      n_cmp++;
      if ({bus_m.out_valid, bus_m.last, bus_m.in_ready} !== {e_valid, e_last, e_rdy}) begin
        n_bad++;
        $display("FAIL rnd_ctl_msb cyc %0d got %b want %b", c, {bus_m.out_valid, bus_m.last, bus_m.in_ready}, {e_valid, e_last, e_rdy});
      end
      if (e_valid || m_fresh) begin
        n_cmp++;
        if ({bus_l.Y, bus_l.S} !== {e_yl, e_sl}) begin
          n_bad++;
          $display("FAIL rnd_data_lsb cyc %0d got %b want %b", c, {bus_l.Y, bus_l.S}, {e_yl, e_sl});
        end
        n_cmp++;
        if ({bus_m.Y, bus_m.S} !== {e_ym, e_sm}) begin
          n_bad++;
          $display("FAIL rnd_data_msb cyc %0d got %b want %b", c, {bus_m.Y, bus_m.S}, {e_ym, e_sm});
        end
      end
      tick();
    end
  endtask

  initial begin
    bus_l.D = 8'h00; bus_l.in_valid = 1'b0; bus_l.out_ready = 1'b0;
    bus_m.D = 8'h00; bus_m.in_valid = 1'b0; bus_m.out_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
